// File: rtl/cache_controller_assoc_if.sv
// Handshake bundle between the associative cache controller and its
// CPU, tag/data arrays and main memory; slave = controller side.
interface cache_controller_assoc_if #(
    parameter int WAYS  = 2,
    parameter int SETS  = 256,
    parameter int WORDS = 4
);
    logic                     rd;
    logic                     wr;
    logic [$clog2(SETS)-1:0]  index;
    logic [WAYS-1:0]          way_hit;
    logic [WAYS-1:0]          way_valid;
    logic [WAYS-1:0]          way_dirty;
    logic                     cache_err;
    logic                     mem_err;
    logic                     mem_stall;
    logic [WAYS-1:0]          way_en;
    logic                     comp;
    logic                     cache_write;
    logic                     valid_in;
    logic [$clog2(WORDS)-1:0] word_sel;
    logic                     tag_sel;
    logic                     mem_rd;
    logic                     mem_wr;
    logic [$clog2(WORDS)-1:0] mem_word;
    logic                     done;
    logic                     hit;
    logic                     stall;
    logic                     err;

    modport master (
        output rd, wr, index, way_hit, way_valid, way_dirty,
        output cache_err, mem_err, mem_stall,
        input  way_en, comp, cache_write, valid_in, word_sel,
        input  tag_sel, mem_rd, mem_wr, mem_word,
        input  done, hit, stall, err
    );

    modport slave (
        input  rd, wr, index, way_hit, way_valid, way_dirty,
        input  cache_err, mem_err, mem_stall,
        output way_en, comp, cache_write, valid_in, word_sel,
        output tag_sel, mem_rd, mem_wr, mem_word,
        output done, hit, stall, err
    );
endinterface

// File: rtl/cache_controller_assoc.sv
// N-way set-associative cache controller: hit check, victim choice,
// pipelined dirty write-back, fixed-latency refill, replay, error abort.
// Ports: clk, rst (async, active-high), bus (slave side of
// cache_controller_assoc_if: CPU req/resp, array status/control, memory).
module cache_controller_assoc #(
    parameter int WAYS        = 2,
    parameter int SETS        = 256,
    parameter int WORDS       = 4,
    parameter int MEM_LATENCY = 2
) (
    input logic                     clk,
    input logic                     rst,
    cache_controller_assoc_if.slave bus
);
    localparam int PW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WW = $clog2(WORDS);
    localparam int LW = MEM_LATENCY;
    localparam logic [WW-1:0] LAST = WW'(WORDS - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] HIT_DONE  = 3'd1;
    localparam logic [2:0] WB        = 3'd2;
    localparam logic [2:0] REFILL    = 3'd3;
    localparam logic [2:0] FILL_WAIT = 3'd4;
    localparam logic [2:0] INSTALL   = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [WW-1:0]   k;
    logic [PW-1:0]   vic;
    logic [PW-1:0]   vic_sel;
    logic [WAYS-1:0] vic_oh;
    logic            err_q;
    logic [PW-1:0]   rr_ptr [SETS];
    logic [LW-1:0]   pv;
    logic [WW-1:0]   pw [LW];
    logic            req;
    logic            conflict;
    logic            any_hit;
    logic            all_valid;
    logic            vic_dirty;
    logic            fault;
    logic            accept;
    logic            last_k;
    logic            head_v;
    logic            push;
    logic [WW-1:0]   head_w;

    // IDLE outputs are held off while reset is asserted
    assign req       = (bus.rd | bus.wr) & ~rst;
    assign conflict  = bus.rd & bus.wr;
    assign any_hit   = |(bus.way_hit & bus.way_valid);
    assign fault     = bus.cache_err | bus.mem_err;
    assign accept    = ~bus.mem_stall;
    assign last_k    = (k == LAST);
    assign head_v    = pv[LW-1];
    assign head_w    = pw[LW-1];
    assign push      = (state == REFILL) & accept;
    assign vic_dirty = bus.way_valid[vic_sel] & bus.way_dirty[vic_sel];

    // lowest invalid way wins; descending scan lets low ways override
    always_comb begin
        vic_sel   = rr_ptr[bus.index];
        all_valid = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!bus.way_valid[w]) begin
                vic_sel   = PW'(w);
                all_valid = 1'b0;
            end
        end
    end

    always_comb begin
        vic_oh = '0;
        for (int w = 0; w < WAYS; w++) begin
            vic_oh[w] = (vic == PW'(w));
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (conflict)     state_nxt = DONE;
                    else if (any_hit) state_nxt = HIT_DONE;
                    else if (vic_dirty) state_nxt = WB;
                    else              state_nxt = REFILL;
                end
            end
            HIT_DONE:  state_nxt = IDLE;
            WB:        if (accept && last_k) state_nxt = REFILL;
            REFILL:    if (accept && last_k) state_nxt = FILL_WAIT;
            FILL_WAIT: if (head_v && head_w == LAST) state_nxt = INSTALL;
            INSTALL:   state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (state != IDLE && state != DONE && fault) state_nxt = DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            vic   <= '0;
            err_q <= 1'b0;
            pv    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                k   <= '0;
                vic <= vic_sel;
            end else if ((state == WB || state == REFILL) && accept) begin
                k <= k + 1'b1;
            end
            if (state == DONE)
                err_q <= 1'b0;
            else if (state != IDLE && fault)
                err_q <= 1'b1;
            else if (state == IDLE && req && conflict)
                err_q <= 1'b1;
            // return pipe: flushed while reporting completion
            if (state == DONE) begin
                pv <= '0;
            end else begin
                for (int i = LW - 1; i > 0; i--) pv[i] <= pv[i-1];
                pv[0] <= push;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = LW - 1; i > 0; i--) pw[i] <= pw[i-1];
        pw[0] <= k;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else if (WAYS > 1 && state == IDLE && req && !conflict
                     && !any_hit && all_valid) begin
            rr_ptr[bus.index] <= rr_ptr[bus.index] + 1'b1;
        end
    end

    always_comb begin
        bus.way_en      = '0;
        bus.comp        = 1'b0;
        bus.cache_write = 1'b0;
        bus.valid_in    = 1'b0;
        bus.word_sel    = '0;
        bus.tag_sel     = 1'b0;
        bus.mem_rd      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_word    = '0;
        bus.done        = 1'b0;
        bus.hit         = 1'b0;
        bus.stall       = 1'b0;
        bus.err         = 1'b0;
        unique case (state)
            IDLE: begin
                bus.way_en      = {WAYS{req}};
                bus.comp        = req;
                bus.cache_write = bus.wr & ~rst;
            end
            HIT_DONE: begin
                bus.done = 1'b1;
                bus.hit  = 1'b1;
            end
            WB: begin
                bus.stall    = 1'b1;
                bus.way_en   = vic_oh;
                bus.word_sel = k;
                bus.tag_sel  = 1'b1;
                bus.mem_wr   = 1'b1;
                bus.mem_word = k;
            end
            REFILL, FILL_WAIT: begin
                bus.stall = 1'b1;
                if (state == REFILL) begin
                    bus.mem_rd   = 1'b1;
                    bus.mem_word = k;
                end
                if (head_v) begin
                    bus.way_en      = vic_oh;
                    bus.cache_write = 1'b1;
                    bus.valid_in    = 1'b1;
                    bus.word_sel    = head_w;
                end
            end
            INSTALL: begin
                bus.stall       = 1'b1;
                bus.way_en      = vic_oh;
                bus.comp        = 1'b1;
                bus.cache_write = bus.wr;
            end
            DONE: begin
                bus.done = 1'b1;
                bus.err  = err_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cache_controller_assoc.sv
// Directed bench for cache_controller_assoc: a per-request timeline
// model built from the access rules, compared every cycle.
module tb_cache_controller_assoc;
    localparam int WAYS  = 2;
    localparam int SETS  = 256;
    localparam int WORDS = 4;
    localparam int LAT   = 2;
    localparam int MAXC  = 48;

    typedef struct packed {
        logic [WAYS-1:0] way_en;
        logic            comp;
        logic            cw;
        logic            vin;
        logic            tag;
        logic            mrd;
        logic            mwr;
        logic            done;
        logic            hit;
        logic            stall;
        logic            err;
        logic [1:0]      wsel;
        logic [1:0]      mword;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cache_controller_assoc_if #(
        .WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)
    ) bus ();

    cache_controller_assoc #(
        .WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t ex [MAXC];
    int   rr_m [SETS];
    int   total = 0;
    int   bad = 0;
    int   cur = 0;
    bit   active = 1'b0;
    int   done_at = -1;
    int   rd_cnt = 0;
    int   fill_way = -1;
    int   ncyc = 0;
    int   hold = 0;

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cur, act, want);
        end
    endtask

    // single compare process: DUT outputs vs. modelled timeline
    always @(negedge clk) begin
        if (active) begin
            chk("way_en", int'(bus.way_en), int'(ex[cur].way_en));
            chk("comp", int'(bus.comp), int'(ex[cur].comp));
            chk("cache_write", int'(bus.cache_write), int'(ex[cur].cw));
            chk("valid_in", int'(bus.valid_in), int'(ex[cur].vin));
            chk("word_sel", int'(bus.word_sel), int'(ex[cur].wsel));
            chk("tag_sel", int'(bus.tag_sel), int'(ex[cur].tag));
            chk("mem_rd", int'(bus.mem_rd), int'(ex[cur].mrd));
            chk("mem_wr", int'(bus.mem_wr), int'(ex[cur].mwr));
            chk("mem_word", int'(bus.mem_word), int'(ex[cur].mword));
            chk("done", int'(bus.done), int'(ex[cur].done));
            chk("hit", int'(bus.hit), int'(ex[cur].hit));
            chk("stall", int'(bus.stall), int'(ex[cur].stall));
            chk("err", int'(bus.err), int'(ex[cur].err));
            if (bus.done && done_at < 0) done_at = cur;
            if (bus.mem_rd) rd_cnt++;
            if (bus.valid_in) fill_way = int'(bus.way_en);
        end
    end

    // timeline model: issue slots are consumed one per unstalled cycle,
    // fills land LAT cycles after each accepted read, replay follows
    // the last fill, completion the cycle after that
    task automatic build(
        input logic r, input logic w,
        input logic [WAYS-1:0] hv, input logic [WAYS-1:0] vv,
        input logic [WAYS-1:0] dv, input int idx,
        input logic [63:0] sm, input int ecyc, input int rcyc
    );
        int c;
        int v;
        int d;
        int lw;
        bit found;
        bit dirty;
        logic [WAYS-1:0] oh;
        int acc [WORDS];
        for (int i = 0; i < MAXC; i++) ex[i] = '0;
        ex[0].way_en = '1;
        ex[0].comp   = 1'b1;
        ex[0].cw     = w;
        if (r && w) begin
            d = 1;
            ex[1].done = 1'b1;
            ex[1].err  = 1'b1;
        end else if ((hv & vv) != '0) begin
            d = 1;
            ex[1].done = 1'b1;
            ex[1].hit  = 1'b1;
        end else begin
            found = 1'b0;
            v = 0;
            for (int i = 0; i < WAYS; i++) begin
                if (!vv[i] && !found) begin
                    v = i;
                    found = 1'b1;
                end
            end
            if (!found) begin
                v = rr_m[idx];
                rr_m[idx] = (rr_m[idx] + 1) % WAYS;
            end
            oh = '0;
            oh[v] = 1'b1;
            dirty = vv[v] && dv[v];
            c = 1;
            if (dirty) begin
                for (int kk = 0; kk < WORDS; kk++) begin
                    do begin
                        ex[c].way_en = oh;
                        ex[c].wsel   = 2'(kk);
                        ex[c].tag    = 1'b1;
                        ex[c].mwr    = 1'b1;
                        ex[c].mword  = 2'(kk);
                        c++;
                    end while (sm[c-1]);
                end
            end
            for (int kk = 0; kk < WORDS; kk++) begin
                do begin
                    ex[c].mrd   = 1'b1;
                    ex[c].mword = 2'(kk);
                    c++;
                end while (sm[c-1]);
                acc[kk] = c - 1;
            end
            for (int kk = 0; kk < WORDS; kk++) begin
                ex[acc[kk]+LAT].way_en = oh;
                ex[acc[kk]+LAT].cw     = 1'b1;
                ex[acc[kk]+LAT].vin    = 1'b1;
                ex[acc[kk]+LAT].wsel   = 2'(kk);
            end
            lw = acc[WORDS-1] + LAT;
            ex[lw+1].way_en = oh;
            ex[lw+1].comp   = 1'b1;
            ex[lw+1].cw     = w;
            for (int i = 1; i <= lw + 1; i++) ex[i].stall = 1'b1;
            d = lw + 2;
            ex[d].done = 1'b1;
            if (ecyc >= 1 && ecyc < d) begin
                for (int i = ecyc + 1; i < MAXC; i++) ex[i] = '0;
                d = ecyc + 1;
                ex[d].done = 1'b1;
                ex[d].err  = 1'b1;
            end
        end
        ncyc = d + 2;
        hold = d;
        if (rcyc >= 0) begin
            for (int i = rcyc; i < MAXC; i++) ex[i] = '0;
            ncyc = rcyc + 3;
            hold = ncyc;
            for (int s = 0; s < SETS; s++) rr_m[s] = 0;
        end
    endtask

    task automatic idle_inputs();
        bus.rd        = 1'b0;
        bus.wr        = 1'b0;
        bus.index     = '0;
        bus.way_hit   = '0;
        bus.way_valid = '0;
        bus.way_dirty = '0;
        bus.cache_err = 1'b0;
        bus.mem_err   = 1'b0;
        bus.mem_stall = 1'b0;
    endtask

    task automatic run(
        input string nm, input logic r, input logic w,
        input logic [WAYS-1:0] hv, input logic [WAYS-1:0] vv,
        input logic [WAYS-1:0] dv, input int idx,
        input logic [63:0] sm, input int ecyc, input bit cerr,
        input int rcyc, input int want_done, input int want_rd,
        input int want_way
    );
        build(r, w, hv, vv, dv, idx, sm, ecyc, rcyc);
        done_at  = -1;
        rd_cnt   = 0;
        fill_way = -1;
        for (int c = 0; c < ncyc; c++) begin
            cur = c;
            active = 1'b1;
            bus.rd        = (c <= hold) ? r : 1'b0;
            bus.wr        = (c <= hold) ? w : 1'b0;
            bus.index     = 8'(idx);
            bus.way_hit   = hv;
            bus.way_valid = vv;
            bus.way_dirty = dv;
            bus.mem_stall = sm[c];
            bus.mem_err   = (c == ecyc) && !cerr;
            bus.cache_err = (c == ecyc) && cerr;
            if (rcyc >= 0 && c >= rcyc) rst = 1'b1;
            @(posedge clk);
            #1;
        end
        active = 1'b0;
        rst = 1'b0;
        idle_inputs();
        chk({nm, "_done_cycle"}, done_at, want_done);
        chk({nm, "_mem_rd_cycles"}, rd_cnt, want_rd);
        if (want_way >= 0) chk({nm, "_fill_way"}, fill_way, want_way);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int s = 0; s < SETS; s++) rr_m[s] = 0;
        idle_inputs();
        bus.rd = 1'b1;
        bus.wr = 1'b1;
        bus.way_hit = 2'b11;
        bus.way_valid = 2'b11;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_way_en", int'(bus.way_en), 0);
        chk("rst_comp", int'(bus.comp), 0);
        chk("rst_cache_write", int'(bus.cache_write), 0);
        chk("rst_mem_rd", int'(bus.mem_rd), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_stall", int'(bus.stall), 0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("hit",         1, 0, 2'b10, 2'b11, 2'b00, 5, 64'h0,
            -1, 0, -1, 1, 0, -1);
        run("clean",       1, 0, 2'b00, 2'b00, 2'b00, 5, 64'h0,
            -1, 0, -1, 8, 4, 1);
        run("clean_rr",    1, 0, 2'b00, 2'b11, 2'b00, 9, 64'h0,
            -1, 0, -1, 8, 4, 1);
        run("dirty",       0, 1, 2'b00, 2'b11, 2'b11, 9, 64'h0,
            -1, 0, -1, 12, 4, 2);
        run("mem_err",     1, 0, 2'b00, 2'b11, 2'b11, 9, 64'h0,
            5, 0, -1, 6, 1, -1);
        run("hit_wr",      0, 1, 2'b01, 2'b11, 2'b00, 9, 64'h0,
            -1, 0, -1, 1, 0, -1);
        run("stall",       1, 0, 2'b00, 2'b01, 2'b00, 3, 64'h0C,
            -1, 0, -1, 10, 6, 2);
        run("conflict",    1, 1, 2'b00, 2'b00, 2'b00, 3, 64'h0,
            -1, 0, -1, 1, 0, -1);
        run("reset_mid",   1, 0, 2'b00, 2'b00, 2'b00, 5, 64'h0,
            -1, 0, 3, -1, 2, -1);
        run("after_reset", 1, 0, 2'b00, 2'b00, 2'b00, 5, 64'h0,
            -1, 0, -1, 8, 4, 1);
        run("dirty_stall", 0, 1, 2'b00, 2'b11, 2'b11, 9, 64'h48,
            -1, 0, -1, 14, 5, 1);
        run("cache_err",   1, 0, 2'b00, 2'b11, 2'b11, 9, 64'h0,
            2, 1, -1, 3, 0, -1);
        run("rr_next",     1, 0, 2'b00, 2'b11, 2'b00, 9, 64'h0,
            -1, 0, -1, 8, 4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_controller_assoc.md
# cache_controller_assoc

- Parametrised N-way set-associative cache controller.
- Sits between the CPU memory stage, the per-way tag/data arrays and the four-bank main memory.
- Handles hit detection and victim selection (lowest invalid way first, then per-set round-robin).
- Handles a pipelined dirty write-back of WORDS words, a pipelined refill with fixed memory latency, and retry of the original access.
- Generalises the single-way controller to WAYS ways, WORDS words per line and MEM_LATENCY, and adds memory back-pressure and error abort.

## Interface
- WAYS, 2: associativity; legal values 1, 2, 4.
- SETS, 256: sets per way; power of two.
- WORDS, 4: words per line; power of two, ≥2.
- MEM_LATENCY, 2: cycles from mem_rd issue to returned word being writable into cache; ≥1.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd, wr  in  1  CPU request; held by CPU until done.
- index  in  log2(SETS)  set index of request (selects round-robin pointer).
- way_hit, way_valid, way_dirty  in  WAYS  per-way tag-match, valid and dirty bits from arrays for current index.
- cache_err  in  1  OR of array errors.
- mem_err  in  1  memory error.
- mem_stall  in  1  memory cannot accept a request this cycle.
- way_en  out  WAYS  one-hot array enable.
- comp  out  1  compare-mode access.
- cache_write  out  1  array write.
- valid_in  out  1  valid bit written on fill.
- word_sel  out  log2(WORDS)  array word offset.
- tag_sel  out  1  memory address tag: 0 = request tag, 1 = victim tag.
- mem_rd, mem_wr  out  1  memory request.
- mem_word  out  log2(WORDS)  memory word offset.
- done, hit, stall, err  out  1  CPU response.

## Operation
- States: IDLE, HIT_DONE, WB, REFILL, FILL_WAIT, INSTALL, DONE.
- IDLE:
  - way_en = all ones, comp = 1, cache_write = wr.
  - rd&wr together → DONE with err.
  - Else if rd|wr and some way has hit&valid → HIT_DONE.
  - Else rd|wr → miss.
  - Victim = lowest-index way with !valid. If every way is valid, victim = rr_ptr[index], and rr_ptr[index] advances by 1 mod WAYS.
  - Victim is latched. Next state is WB if the victim is valid&dirty, else REFILL.
- HIT_DONE: done = 1, hit = 1 → IDLE.
- WB:
  - Per word k: way_en = victim, comp = 0, word_sel = k, tag_sel = 1, mem_wr = 1, mem_word = k.
  - k advances only when mem_stall = 0.
  - After k = WORDS-1 is accepted → REFILL.
- REFILL:
  - Issue mem_rd with mem_word = k, tag_sel = 0; k advances only when mem_stall = 0.
  - Each accepted read pushes k into a MEM_LATENCY-deep return pipe.
  - After last issue → FILL_WAIT.
- Fill write, in REFILL and FILL_WAIT, when the pipe head is valid:
  - way_en = victim, comp = 0, cache_write = 1, valid_in = 1, word_sel = returned k.
  - This is independent of mem_stall and takes priority over nothing: no array read occurs in these states.
- FILL_WAIT → INSTALL once the last word is written.
- INSTALL: way_en = victim, comp = 1, cache_write = wr; replays the access, which now hits.
- DONE: done = 1, hit = 0 → IDLE.
- Error:
  - cache_err or mem_err in any non-IDLE state sets a sticky error flag and forces DONE.
  - In DONE, err = 1 and done = 1. The return pipe is flushed and the flag clears on entering IDLE.
  - The rd&wr conflict also sets err in DONE.
- WAYS = 1: the victim is always way 0 and rr_ptr is unused.

## Timing
- Reset: state = IDLE, all rr_ptr = 0, return pipe empty, err flag clear.
- Every output is 0 during reset except the IDLE-state combinational values, which require rd|wr.
- Reset mid-miss aborts immediately and issues no further memory requests.
- stall = 1 in WB, REFILL, FILL_WAIT and INSTALL; 0 in IDLE, HIT_DONE and DONE.
- Request is accepted in cycle 0.
- Hit: done in cycle 1.
- Clean miss without mem_stall: done in cycle WORDS+MEM_LATENCY+2.
- Dirty miss without mem_stall: done in cycle 2·WORDS+MEM_LATENCY+2.
- Each mem_stall cycle during issue adds 1 cycle.
- done is a single-cycle pulse; the CPU drops rd/wr in the cycle after done. The FSM is in IDLE that cycle.

## Test plan
- WAYS=2, rd hits way 1 → way_en = 2'b11 in cycle 0; done = hit = 1 in cycle 1; no mem_rd.
- Clean rd miss, both ways invalid, WORDS=4, LAT=2:
  - victim = way 0.
  - mem_rd words 0-3 in cycles 1-4.
  - cache_write with word_sel 0-3 in cycles 3-6.
  - done = 1, hit = 0 in cycle 8.
- Dirty wr miss, both valid, rr_ptr = 1:
  - mem_wr with tag_sel = 1 in cycles 1-4.
  - mem_rd in cycles 5-8.
  - INSTALL in cycle 11 with cache_write = 1, way_en = 2'b10.
  - done in cycle 12; rr_ptr[index] = 0 afterwards.
- mem_stall high in cycles 2-3 of a clean miss → mem_word 1 held for 3 cycles; done in cycle 10.
- mem_err pulse in cycle 5 of a dirty miss → done = err = 1 in cycle 6; no further mem_rd; next request behaves normally.
- rst asserted in cycle 3 of a refill → all outputs 0 immediately; the next identical request repeats the full miss sequence.
